spi_flash_resp: RTL and testbench
=================================

// Module: spi_flash_resp
// PURPOSE
//  Synthesizable SPI-flash responder (mode 0) holding a byte array; the slave end of the SoC's spi0 master link
//  (fpioa[4..7] = miso/mosi/sclk/cs). Used on FPGA boards with no flash fitted, and as a light bench model
//  replacing the vendor W25Q model. All SPI inputs are oversampled in the clk domain.
// PARAMETERS
//  DEPTH     1024      memory size in bytes, power of two, >=16
//  JEDEC_ID  24'hEF4018 returned by 0x9F, MSB first
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  spi_cs_n     in   1   chip select, active low
//  spi_sclk     in   1   SPI clock, idle low, f_sclk <= f_clk/8
//  spi_mosi     in   1   master out
//  spi_miso     out  1   slave out
//  spi_miso_oe  out  1   high while cs_n low and state drives data
//  wr_strobe    out  1   one-clk pulse per committed program byte
//  cmd_err      out  1   sticky; set by unknown opcode, cleared by reset
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, wr_strobe=0, cmd_err=0, state IDLE, wel=0. Memory contents are not reset.
//  Sync: cs_n/sclk/mosi go through 2 flops; rise/fall of sclk are detected from the synced sclk and its previous value.
//    Internal reaction is therefore 3 clk after a pin edge.
//  Mode 0: mosi sampled on sclk rise (MSB first); miso shifted on sclk fall. The first response bit is driven after
//    the fall that follows the last rise of the cmd/addr phase.
//  States: IDLE -> CMD on synced cs_n fall; CMD collects 8 bits, then decodes:
//    0x03 READ  -> ADDR -> RDATA.
//    0x02 PROG  -> ADDR -> WDATA.
//    0x9F ID    -> ID (3 bytes, then 0x00 forever).
//    0x05 RDSR  -> STAT (status byte repeated).
//    others     -> IGNORE, set cmd_err.
//  ADDR: 24 bits MSB first; index = addr[$clog2(DEPTH)-1:0]; upper bits ignored.
//  RDATA: streams mem[idx], idx+1, ...; idx wraps DEPTH-1 -> 0. The next byte is fetched on the rise of its
//    preceding byte's bit 0.
//  WDATA: each complete 8-bit byte overwrites mem[idx] (no AND semantics), pulses wr_strobe, idx+1 with wrap.
//  Status byte: bit0 BUSY=0 always; bit1 WEL (see CONFIGURATION); other bits 0.
//  Synced cs_n rise in any state -> IDLE within 1 clk and spi_miso_oe=0; a partial byte is discarded, never written.
//  Reset mid-transfer aborts exactly like cs_n rise; no memory write of a pending byte.
//  sclk edges while cs_n high are ignored. cs_n fall with sclk high: the first fall is ignored (no shift).
//  Simultaneous cs_n rise and sclk rise (same synced clk): cs_n wins, the bit is dropped.
// CONFIGURATION
//  SPI_RESP_WEL_EN defined:
//    0x06 WREN sets wel; 0x04 WRDI clears it; both opcodes are legal, with no cmd_err.
//    PROG with wel=0 goes to IGNORE: no writes, no cmd_err.
//    cs_n rise ending a PROG clears wel.
//    Status bit1 = wel.
//  Not defined:
//    0x06/0x04 are unknown opcodes, setting cmd_err.
//    PROG always accepted.
//    Status bit1 reads 0.
// STRUCTURE
//  Package spi_resp_pkg: opcode localparams (OP_READ, OP_PROG, OP_RDID, OP_RDSR, OP_WREN, OP_WRDI),
//    typedef enum logic [2:0] state_e {IDLE, CMD, ADDR, RDATA, WDATA, ID, STAT, IGNORE}.
//  Sub-module spi_resp_sync: 2-flop synchronizer + rise/fall pulse for one bit; instanced for cs_n, sclk, mosi.
//  Top holds the FSM, bit counter (3b), byte counter (2b, addr/ID), shift regs and the reg-array memory.
// TESTING  (clk 100 MHz, sclk 10 MHz, bench SPI master task)
//  1 Reset: rst_n=0 with cs_n=1 -> spi_miso=0, spi_miso_oe=0, cmd_err=0; after release, no activity.
//  2 PROG 0x000010, data A5 3C (WEL_EN: after WREN), then READ 0x000010 for 2 bytes -> A5 3C; wr_strobe pulses twice.
//  3 Wrap: PROG DEPTH-1 with 11 22, then READ 0xFFFFFF (DEPTH=1024) for 2 bytes -> 11 22; mem[0]=0x22.
//  4 RDID 4 bytes -> EF 40 18 00; RDSR -> 0x00 (WEL_EN after WREN -> 0x02, after a PROG -> 0x00).
//  5 Abort: PROG 0x20, send 0x77 then 5 bits of 0xFF, cs_n high -> mem[0x20]=0x77, mem[0x21] unchanged, one wr_strobe.
//  6 Opcode 0xAB -> cmd_err=1, miso_oe stays 0. Then rst_n pulse mid-READ -> oe=0, cmd_err=0; next READ is correct.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared opcodes and FSM state encoding for the SPI-flash responder.
package spi_resp_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PROG = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RDATA, WDATA, ID, STAT, IGNORE
  } state_e;

  // True for the two write-enable latch opcodes.
  function automatic logic is_wel_op(input logic [7:0] op);
    return (op == OP_WREN) || (op == OP_WRDI);
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchronizer for one SPI pin, plus rise/fall pulses taken from
// the synchronized level and its previous value.
module spi_resp_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_prev;

  // Synchronize the pin and keep one cycle of history for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RST_VAL;
      q      <= RST_VAL;
      q_prev <= RST_VAL;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI-flash responder (mode 0) backed by a byte array.
// Commands: READ 0x03, PROG 0x02, RDID 0x9F, RDSR 0x05.
// Build option SPI_RESP_WEL_EN: adds WREN 0x06 / WRDI 0x04 and gates PROG on wel.
module spi_flash_resp import spi_resp_pkg::*; #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic wr_strobe,
  output logic cmd_err
);

  localparam int AW = $clog2(DEPTH);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  // cs_n idles high, so its synchronizer resets high to avoid a false fall.
  spi_resp_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_sync), .rise(cs_rise), .fall(cs_fall));
  spi_resp_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_resp_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e          state;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [AW-1:0]   idx;
  logic [6:0]      rx_sr;
  logic [7:0]      tx_sr;
  logic            prog_cmd;
  logic            wel;
  logic            prog_ok;
  logic            wel_op;
  logic [7:0]      mem [DEPTH];

  // sclk edges while cs_n is high never count; cs_n rising also beats a same-cycle sclk rise.
  logic          bit_edge, byte_end, mem_we;
  logic [7:0]    rx_byte, status;
  logic [AW-1:0] addr_idx;

  assign bit_edge = sclk_rise & ~cs_sync;
  assign byte_end = bit_edge & (bit_cnt == 3'd7);
  assign rx_byte  = {rx_sr, mosi_sync};
  assign addr_idx = {idx[AW-2:0], mosi_sync};
  assign mem_we   = (state == WDATA) & byte_end;
  assign status   = {6'b0, wel, 1'b0};

`ifdef SPI_RESP_WEL_EN
  assign prog_ok = wel;
  assign wel_op  = is_wel_op(rx_byte);

  // Write-enable latch: set by WREN, cleared by WRDI or by the end of a PROG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wel <= 1'b0;
    end else if (state == CMD && byte_end && rx_byte == OP_WREN) begin
      wel <= 1'b1;
    end else if (state == CMD && byte_end && rx_byte == OP_WRDI) begin
      wel <= 1'b0;
    end else if (cs_rise && prog_cmd) begin
      wel <= 1'b0;
    end
  end
`else
  assign prog_ok = 1'b1;
  assign wel_op  = 1'b0;
  assign wel     = 1'b0;
`endif

  // Byte array write port; only complete bytes in WDATA reach it.
  // NOTE: memory has no reset; its contents survive rst_n and start undefined.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= rx_byte;
  end

  // Protocol FSM: command decode, address collection, data streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      idx         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      prog_cmd    <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      wr_strobe <= mem_we;
      if (cs_sync) begin
        // Deselected: abort whatever was in flight, partial bytes dropped.
        state       <= IDLE;
        bit_cnt     <= '0;
        prog_cmd    <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (bit_edge) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sr   <= rx_byte[6:0];
        end
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
          CMD: begin
            if (byte_end) begin
              byte_cnt <= '0;
              case (rx_byte)
                OP_READ: begin
                  state    <= ADDR;
                  prog_cmd <= 1'b0;
                end
                OP_PROG: begin
                  if (prog_ok) begin
                    state    <= ADDR;
                    prog_cmd <= 1'b1;
                  end else begin
                    state <= IGNORE;
                  end
                end
                OP_RDID: begin
                  state       <= ID;
                  spi_miso_oe <= 1'b1;
                  tx_sr       <= JEDEC_ID[23:16];
                  byte_cnt    <= 2'd1;
                end
                OP_RDSR: begin
                  state       <= STAT;
                  spi_miso_oe <= 1'b1;
                  tx_sr       <= status;
                end
                default: begin
                  state <= IGNORE;
                  if (!wel_op) cmd_err <= 1'b1;
                end
              endcase
            end
          end
          ADDR: begin
            // idx doubles as the address shift register; upper address bits fall off the top.
            if (bit_edge) idx <= addr_idx;
            if (byte_end) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                if (prog_cmd) begin
                  state <= WDATA;
                end else begin
                  state       <= RDATA;
                  spi_miso_oe <= 1'b1;
                  tx_sr       <= mem[addr_idx];
                  idx         <= addr_idx + 1'b1;
                end
              end
            end
          end
          RDATA: begin
            if (byte_end) begin
              tx_sr <= mem[idx];
              idx   <= idx + 1'b1;
            end
          end
          WDATA: begin
            if (byte_end) idx <= idx + 1'b1;
          end
          ID: begin
            if (byte_end) begin
              case (byte_cnt)
                2'd1:    tx_sr <= JEDEC_ID[15:8];
                2'd2:    tx_sr <= JEDEC_ID[7:0];
                default: tx_sr <= 8'h00;
              endcase
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            end
          end
          STAT: begin
            if (byte_end) tx_sr <= status;
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
        // Response bits leave on sclk fall, MSB first.
        if (sclk_fall && spi_miso_oe) begin
          spi_miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: clk 100 MHz, sclk 10 MHz mode-0 master tasks.
// Works with or without SPI_RESP_WEL_EN defined.
module tb_spi_flash_resp;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, wr_strobe, cmd_err;

  int n_vec      = 0;
  int n_err      = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  spi_flash_resp #(.DEPTH(1024), .JEDEC_ID(24'hEF4018)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_strobe(wr_strobe), .cmd_err(cmd_err));

  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_start();
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic spi_stop();
    #50;
    spi_cs_n = 1'b1;
    #100;
  endtask

  // Clock n bits of tx out MSB first; miso is sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #50;
      rx[i]    = spi_miso;
      spi_sclk = 1'b1;
      #50;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    spi_start();
    spi_byte(op, d);
    spi_byte(a[23:16], d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  task automatic wren();
`ifdef SPI_RESP_WEL_EN
    logic [7:0] d;
    spi_start();
    spi_byte(8'h06, d);
    spi_stop();
`endif
  endtask

  task automatic prog2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] d;
    wren();
    cmd_addr(8'h02, a);
    spi_byte(b0, d);
    spi_byte(b1, d);
    spi_stop();
  endtask

  task automatic read2(input logic [23:0] a, output logic [7:0] r0, output logic [7:0] r1);
    cmd_addr(8'h03, a);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_stop();
  endtask

  task automatic rdsr(output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] d;
    spi_start();
    spi_byte(8'h05, d);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_stop();
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    int s0;

    // 1: reset state, then sclk activity with cs_n high must do nothing
    #30;
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_err", cmd_err, 0);
    check("rst_strobe", wr_strobe, 0);
    rst_n = 1'b1;
    #50;
    repeat (8) begin
      spi_mosi = ~spi_mosi;
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
    #100;
    check("idle_oe", spi_miso_oe, 0);
    check("idle_err", cmd_err, 0);
    check("idle_strobes", strobe_cnt, 0);

    // 2: program two bytes at 0x10 and read them back
    s0 = strobe_cnt;
    prog2(24'h000010, 8'hA5, 8'h3C);
    check("prog_strobes", strobe_cnt - s0, 2);
    cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, r0);
    check("rd_oe_on", spi_miso_oe, 1);
    spi_byte(8'h00, r1);
    spi_stop();
    check("rd_oe_off", spi_miso_oe, 0);
    check("rd10_b0", r0, 8'hA5);
    check("rd10_b1", r1, 8'h3C);

    // 3: wrap at DEPTH-1, upper address bits ignored
    prog2(24'h0003FF, 8'h11, 8'h22);
    read2(24'hFFFFFF, r0, r1);
    check("wrap_b0", r0, 8'h11);
    check("wrap_b1", r1, 8'h22);
    read2(24'h000000, r0, r1);
    check("wrap_mem0", r0, 8'h22);

    // 4: JEDEC ID then zeros; status register
    spi_start();
    spi_byte(8'h9F, r0);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    spi_byte(8'h00, r3);
    spi_stop();
    check("id_b0", r0, 8'hEF);
    check("id_b1", r1, 8'h40);
    check("id_b2", r2, 8'h18);
    check("id_b3", r3, 8'h00);
    rdsr(r0, r1);
    check("sr_b0", r0, 8'h00);
    check("sr_b1", r1, 8'h00);
`ifdef SPI_RESP_WEL_EN
    wren();
    rdsr(r0, r1);
    check("sr_wel_b0", r0, 8'h02);
    check("sr_wel_b1", r1, 8'h02);
    spi_start();
    spi_byte(8'h04, r2);
    spi_stop();
    rdsr(r0, r1);
    check("sr_wrdi", r0, 8'h00);
    // PROG without WREN is silently dropped
    s0 = strobe_cnt;
    cmd_addr(8'h02, 24'h000010);
    spi_byte(8'hFF, r2);
    spi_stop();
    check("nowel_strobes", strobe_cnt - s0, 0);
    read2(24'h000010, r0, r1);
    check("nowel_mem", r0, 8'hA5);
`endif

    // 5: abort mid-byte keeps only the completed byte
    prog2(24'h000020, 8'h00, 8'h5A);
    s0 = strobe_cnt;
    wren();
    cmd_addr(8'h02, 24'h000020);
    spi_byte(8'h77, r0);
    spi_bits(8'hFF, 5, r0);
    spi_stop();
    check("abort_strobes", strobe_cnt - s0, 1);
    read2(24'h000020, r0, r1);
    check("abort_b0", r0, 8'h77);
    check("abort_b1", r1, 8'h5A);

    // 6: unknown opcode, then reset in the middle of a READ
    check("err_clean", cmd_err, 0);
    spi_start();
    spi_byte(8'hAB, r0);
    spi_byte(8'h00, r0);
    check("ign_oe", spi_miso_oe, 0);
    spi_stop();
    check("ign_err", cmd_err, 1);
    check("ign_oe_end", spi_miso_oe, 0);
    cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, r0);
    check("pre_rst_b0", r0, 8'hA5);
    spi_bits(8'h00, 3, r1);
    rst_n = 1'b0;
    #30;
    check("midrst_oe", spi_miso_oe, 0);
    check("midrst_err", cmd_err, 0);
    check("midrst_miso", spi_miso, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    #50;
    rst_n = 1'b1;
    #100;
    check("post_rst_err", cmd_err, 0);
    read2(24'h000010, r0, r1);
    check("post_rst_b0", r0, 8'hA5);
    check("post_rst_b1", r1, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
